// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller slice.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        BRFLUSH
    } hz_state_t;

    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; master is the datapath side.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    import pipe_pkg::*;

    logic [3:0]       RA1D, RA2D, RA1E, RA2E;
    logic [3:0]       WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW;
    logic             MemToRegE;
    logic             BranchTakenE;
    logic             mem_req, mem_ack;
    fwd_sel_t         ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
        output mem_req, mem_ack,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
        input  FlushD, FlushE, stall_cnt
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemToRegE, BranchTakenE,
        input  mem_req, mem_ack,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
        output FlushD, FlushE, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// Operand forwarding select for one Execute-stage ALU input.
module fwd_unit
    import pipe_pkg::*;
(
    input  logic [3:0] i_ra,
    input  logic [3:0] i_wa3m,
    input  logic [3:0] i_wa3w,
    input  logic       i_regwritem,
    input  logic       i_regwritew,
    output fwd_sel_t   o_fwd
);

    logic w_hit_m;
    logic w_hit_w;

    // PC is never forwarded: its value comes from the fetch path, not the ALU.
    assign w_hit_m = i_regwritem && (i_wa3m == i_ra) && (i_wa3m != PC_REG);
    assign w_hit_w = i_regwritew && (i_wa3w == i_ra) && (i_wa3w != PC_REG);

    always_comb begin
        o_fwd = FWD_RF;
        if (w_hit_m)
            o_fwd = FWD_MEM;
        else if (w_hit_w)
            o_fwd = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing, forwarding selects and stall-cycle counter for the
// 5-stage pipeline.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned BR_FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W           = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam logic [1:0] BR_LOAD = 2'(BR_FLUSH_CYCLES - 1);

    hz_state_t        r_state, w_next;
    logic [1:0]       r_flush_cnt, w_flush_cnt_next;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_ldhaz;
    logic             w_stallf, w_stalld, w_stalle, w_flushd, w_flushe;

    fwd_unit u_fwd_a (
        .i_ra        (hz.RA1E),
        .i_wa3m      (hz.WA3M),
        .i_wa3w      (hz.WA3W),
        .i_regwritem (hz.RegWriteM),
        .i_regwritew (hz.RegWriteW),
        .o_fwd       (hz.ForwardAE)
    );

    fwd_unit u_fwd_b (
        .i_ra        (hz.RA2E),
        .i_wa3m      (hz.WA3M),
        .i_wa3w      (hz.WA3W),
        .i_regwritem (hz.RegWriteM),
        .i_regwritew (hz.RegWriteW),
        .o_fwd       (hz.ForwardBE)
    );

    assign w_ldhaz = hz.MemToRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    always_comb begin
        w_next           = r_state;
        w_flush_cnt_next = r_flush_cnt;
        case (r_state)
            RUN: begin
                if (hz.mem_req) begin
                    w_next = MEMWAIT;
                end else if (hz.BranchTakenE) begin
                    w_flush_cnt_next = BR_LOAD;
                    w_next = (BR_FLUSH_CYCLES == 1) ? RUN : BRFLUSH;
                end
            end
            MEMWAIT: begin
                if (hz.mem_ack)
                    w_next = RUN;
            end
            BRFLUSH: begin
                // The counter holds the flush cycles still owed including this one.
                if (hz.mem_req) begin
                    w_next           = MEMWAIT;
                    w_flush_cnt_next = '0;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 2'd1;
                    if (r_flush_cnt <= 2'd1)
                        w_next = RUN;
                end
            end
            default: w_next = RUN;
        endcase
    end

    // Gated by rst so the pipe sees no stall/flush while reset is held.
    always_comb begin
        w_stallf = 1'b0;
        w_stalld = 1'b0;
        w_stalle = 1'b0;
        w_flushd = 1'b0;
        w_flushe = 1'b0;
        if (rst) begin
            case (r_state)
                RUN: begin
                    if (hz.mem_req) begin
                        w_stallf = 1'b1;
                        w_stalld = 1'b1;
                        w_stalle = 1'b1;
                    end else if (hz.BranchTakenE) begin
                        w_flushd = 1'b1;
                        w_flushe = 1'b1;
                    end else if (w_ldhaz) begin
                        w_stallf = 1'b1;
                        w_stalld = 1'b1;
                        w_flushe = 1'b1;
                    end
                end
                MEMWAIT: begin
                    w_stallf = !hz.mem_ack;
                    w_stalld = !hz.mem_ack;
                    w_stalle = !hz.mem_ack;
                end
                BRFLUSH: begin
                    if (hz.mem_req) begin
                        w_stallf = 1'b1;
                        w_stalld = 1'b1;
                        w_stalle = 1'b1;
                    end else begin
                        w_flushd = 1'b1;
                        w_flushe = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (w_stallf && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

    assign hz.StallF    = w_stallf;
    assign hz.StallD    = w_stalld;
    assign hz.StallE    = w_stalle;
    assign hz.FlushD    = w_flushd;
    assign hz.FlushE    = w_flushe;
    assign hz.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// multi-cycle sequences for branch flush, memory wait, priority and saturation.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_tests;
    int unsigned n_fail;

    pipe_hazard_ctrl_if #(.CNT_W(4)) hz_if ();

    pipe_hazard_ctrl #(
        .BR_FLUSH_CYCLES (2),
        .CNT_W           (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ra1e, ra2e, wa3m, wa3w;
        logic       rwm, rww;
        logic       m2r;
        logic [3:0] wa3e, ra1d, ra2d;
        logic [1:0] exp_a, exp_b;
        logic [4:0] exp_ctl; // {StallF, StallD, StallE, FlushD, FlushE}
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl();
        return {hz_if.StallF, hz_if.StallD, hz_if.StallE, hz_if.FlushD, hz_if.FlushE};
    endfunction

    task automatic clr_inputs();
        hz_if.RA1D = '0; hz_if.RA2D = '0; hz_if.RA1E = '0; hz_if.RA2E = '0;
        hz_if.WA3E = '0; hz_if.WA3M = '0; hz_if.WA3W = '0;
        hz_if.RegWriteM = 1'b0; hz_if.RegWriteW = 1'b0;
        hz_if.MemToRegE = 1'b0; hz_if.BranchTakenE = 1'b0;
        hz_if.mem_req = 1'b0; hz_if.mem_ack = 1'b0;
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        rst = 1'b0;
        clr_inputs();
        #2;
        chk({name, "_rst_ctl"}, ctl(), 5'b00000);
        chk({name, "_rst_cnt"}, hz_if.stall_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic set_ldhaz();
        hz_if.MemToRegE = 1'b1;
        hz_if.WA3E = 4'd5;
        hz_if.RA1D = 4'd5;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b0;
        clr_inputs();

        // Reset with requests pending: controls must stay low.
        hz_if.mem_req = 1'b1;
        hz_if.BranchTakenE = 1'b1;
        #3;
        chk("reset_ctl_gated", ctl(), 5'b00000);
        chk("reset_cnt", hz_if.stall_cnt, 0);
        hz_if.RegWriteM = 1'b1; hz_if.WA3M = 4'd3; hz_if.RA1E = 4'd3;
        #1;
        chk("reset_fwd_follows", hz_if.ForwardAE, 2'b10);
        clr_inputs();
        @(negedge clk);
        rst = 1'b1;

        //        ra1e ra2e wa3m wa3w rwm rww m2r wa3e ra1d ra2d  A      B      ctl
        vecs[0] = '{4'd3, 4'd4, 4'd3, 4'd3, 1, 1, 1, 4'd5, 4'd5, 4'd0, 2'b10, 2'b00, 5'b11001};
        vecs[1] = '{4'd3, 4'd4, 4'd3, 4'd3, 0, 1, 0, 4'd5, 4'd5, 4'd0, 2'b01, 2'b00, 5'b00000};
        vecs[2] = '{4'd15,4'd15,4'd15,4'd15,1, 1, 1, 4'd5, 4'd0, 4'd5, 2'b00, 2'b00, 5'b11001};
        vecs[3] = '{4'd2, 4'd7, 4'd7, 4'd7, 1, 1, 1, 4'd2, 4'd3, 4'd4, 2'b00, 2'b10, 5'b00000};
        vecs[4] = '{4'd1, 4'd9, 4'd9, 4'd9, 0, 1, 0, 4'd0, 4'd0, 4'd0, 2'b00, 2'b01, 5'b00000};
        vecs[5] = '{4'd15,4'd6, 4'd15,4'd6, 1, 1, 0, 4'd0, 4'd1, 4'd1, 2'b00, 2'b01, 5'b00000};
        vecs[6] = '{4'd6, 4'd8, 4'd6, 4'd8, 1, 1, 0, 4'd0, 4'd1, 4'd2, 2'b10, 2'b01, 5'b00000};
        vecs[7] = '{4'd6, 4'd8, 4'd6, 4'd8, 0, 0, 1, 4'd8, 4'd8, 4'd8, 2'b00, 2'b00, 5'b11001};

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            hz_if.RA1E = vecs[i].ra1e; hz_if.RA2E = vecs[i].ra2e;
            hz_if.WA3M = vecs[i].wa3m; hz_if.WA3W = vecs[i].wa3w;
            hz_if.RegWriteM = vecs[i].rwm; hz_if.RegWriteW = vecs[i].rww;
            hz_if.MemToRegE = vecs[i].m2r; hz_if.WA3E = vecs[i].wa3e;
            hz_if.RA1D = vecs[i].ra1d; hz_if.RA2D = vecs[i].ra2d;
            #2;
            chk($sformatf("vec%0d_fwdA", i), hz_if.ForwardAE, vecs[i].exp_a);
            chk($sformatf("vec%0d_fwdB", i), hz_if.ForwardBE, vecs[i].exp_b);
            chk($sformatf("vec%0d_ctl", i), ctl(), vecs[i].exp_ctl);
        end

        // Load-use: one stall cycle, counter 0 -> 1.
        do_reset("ldhaz");
        hz_if.MemToRegE = 1'b1; hz_if.WA3E = 4'd5; hz_if.RA2D = 4'd5;
        #2;
        chk("ldhaz_ctl", ctl(), 5'b11001);
        chk("ldhaz_cnt0", hz_if.stall_cnt, 0);
        @(negedge clk);
        clr_inputs();
        #2;
        chk("ldhaz_after_ctl", ctl(), 5'b00000);
        chk("ldhaz_cnt1", hz_if.stall_cnt, 1);

        // Branch: two flush cycles, ldHaz ignored in the second, honoured after.
        do_reset("br");
        hz_if.BranchTakenE = 1'b1;
        #2;
        chk("br_c1_ctl", ctl(), 5'b00011);
        @(negedge clk);
        hz_if.BranchTakenE = 1'b0;
        set_ldhaz();
        #2;
        chk("br_c2_ctl", ctl(), 5'b00011);
        @(negedge clk);
        #2;
        chk("br_c3_ldhaz_ctl", ctl(), 5'b11001);
        @(negedge clk);
        clr_inputs();
        #2;
        chk("br_c4_ctl", ctl(), 5'b00000);
        chk("br_cnt", hz_if.stall_cnt, 1);

        // Memory wait: request cycle + 4 wait cycles stalled, ack cycle released.
        do_reset("mem");
        hz_if.mem_req = 1'b1;
        #2;
        chk("mem_req_ctl", ctl(), 5'b11100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            chk($sformatf("mem_wait%0d_ctl", i), ctl(), 5'b11100);
        end
        @(negedge clk);
        hz_if.mem_req = 1'b0;
        hz_if.mem_ack = 1'b1;
        #2;
        chk("mem_ack_ctl", ctl(), 5'b00000);
        @(negedge clk);
        #2;
        chk("mem_stray_ack_ctl", ctl(), 5'b00000);
        chk("mem_cnt5", hz_if.stall_cnt, 5);
        @(negedge clk);
        hz_if.mem_ack = 1'b0;
        #2;
        chk("mem_idle_ctl", ctl(), 5'b00000);

        // mem_req beats BranchTakenE.
        do_reset("prio");
        hz_if.mem_req = 1'b1;
        hz_if.BranchTakenE = 1'b1;
        #2;
        chk("prio_c1_ctl", ctl(), 5'b11100);
        @(negedge clk);
        hz_if.BranchTakenE = 1'b0;
        hz_if.mem_req = 1'b0;
        #2;
        chk("prio_c2_wait_ctl", ctl(), 5'b11100);
        @(negedge clk);
        hz_if.mem_ack = 1'b1;
        #2;
        chk("prio_ack_ctl", ctl(), 5'b00000);

        // mem_req during BRFLUSH abandons the flush.
        do_reset("brmem");
        hz_if.BranchTakenE = 1'b1;
        #2;
        chk("brmem_c1_ctl", ctl(), 5'b00011);
        @(negedge clk);
        hz_if.BranchTakenE = 1'b0;
        hz_if.mem_req = 1'b1;
        #2;
        chk("brmem_c2_ctl", ctl(), 5'b11100);
        @(negedge clk);
        hz_if.mem_req = 1'b0;
        #2;
        chk("brmem_c3_wait_ctl", ctl(), 5'b11100);

        // Saturation at 15, then asynchronous reset mid-wait.
        do_reset("sat");
        hz_if.mem_req = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        chk("sat_cnt15", hz_if.stall_cnt, 15);
        chk("sat_ctl", ctl(), 5'b11100);
        rst = 1'b0;
        #1;
        chk("sat_rst_ctl", ctl(), 5'b00000);
        chk("sat_rst_cnt", hz_if.stall_cnt, 0);
        @(negedge clk);
        hz_if.mem_req = 1'b0;
        rst = 1'b1;
        #2;
        chk("sat_post_rst_ctl", ctl(), 5'b00000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
